// File: rtl/sram_addr_gen.sv
// sram_addr_gen: serial-loaded SRAM address register with increment and AVR/SNES bus mux
module sram_addr_gen (
    input  logic        avr_clk,
    input  logic        avr_reset_n,
    input  logic        avr_si,
    input  logic        avr_sreg_en_n,
    input  logic        avr_counter_n,
    input  logic        avr_oe_n,
    input  logic        avr_we_n,
    input  logic        avr_snes_mode,
    input  logic [23:0] snes_addr,
    input  logic        snes_rd_n,
    input  logic        snes_wr_n,
    output logic [23:0] sram_addr,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        load_done,
    output logic        load_err,
    output logic        busy
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t      state, state_nxt;
    logic [23:0] shadow, addr_reg;
    logic [4:0]  bit_cnt;
    logic        cnt_q, commit, inc_req;
    always_ff @(posedge avr_clk or negedge avr_reset_n)
        if (!avr_reset_n) state <= IDLE;
        else              state <= state_nxt;
    always_comb state_nxt = avr_sreg_en_n ? IDLE : SHIFT;
    always_comb begin
        busy      = state == SHIFT;
        commit    = busy && avr_sreg_en_n;
        inc_req   = cnt_q && !avr_counter_n;
        sram_addr = avr_snes_mode ? snes_addr : addr_reg;
        sram_oe_n = avr_snes_mode ? snes_rd_n : avr_oe_n;
        sram_we_n = avr_snes_mode ? (snes_wr_n | ~snes_rd_n) : (avr_we_n | ~avr_oe_n);
    end
    // Increments only apply in IDLE, so a request on the commit edge is dropped.
    always_ff @(posedge avr_clk or negedge avr_reset_n)
        if (!avr_reset_n) begin
            shadow    <= '0;
            bit_cnt   <= '0;
            addr_reg  <= '0;
            cnt_q     <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            cnt_q     <= avr_counter_n;
            load_done <= commit && bit_cnt == 5'd24;
            load_err  <= commit && bit_cnt != 5'd24;
            if (commit) begin
                bit_cnt <= '0;
                if (bit_cnt == 5'd24) addr_reg <= shadow;
            end else if (busy) begin
                shadow  <= {shadow[22:0], avr_si};
                bit_cnt <= bit_cnt == 5'd24 ? bit_cnt : bit_cnt + 5'd1;
            end else if (inc_req) begin
                addr_reg <= addr_reg + 24'd1;
            end
        end
endmodule

// File: tb/tb_sram_addr_gen.sv
// tb_sram_addr_gen: directed checks of load, increment, mux and reset behaviour
module tb_sram_addr_gen;
    logic        avr_clk = 0, avr_reset_n = 0, avr_si = 0, avr_sreg_en_n = 1;
    logic        avr_counter_n = 1, avr_oe_n = 1, avr_we_n = 1, avr_snes_mode = 0;
    logic [23:0] snes_addr = '0;
    logic        snes_rd_n = 1, snes_wr_n = 1;
    logic [23:0] sram_addr;
    logic        sram_oe_n, sram_we_n, load_done, load_err, busy;
    int          n_chk = 0, n_fail = 0;

    sram_addr_gen dut (
        .avr_clk(avr_clk), .avr_reset_n(avr_reset_n), .avr_si(avr_si),
        .avr_sreg_en_n(avr_sreg_en_n), .avr_counter_n(avr_counter_n),
        .avr_oe_n(avr_oe_n), .avr_we_n(avr_we_n), .avr_snes_mode(avr_snes_mode),
        .snes_addr(snes_addr), .snes_rd_n(snes_rd_n), .snes_wr_n(snes_wr_n),
        .sram_addr(sram_addr), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .load_done(load_done), .load_err(load_err), .busy(busy)
    );

    always #5 avr_clk = ~avr_clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Enters SHIFT, shifts n bits of v MSB first, then raises avr_sreg_en_n and
    // returns just after the commit edge (pulse outputs visible).
    task automatic load(input logic [31:0] v, input int n, input logic cnt_fall);
        @(negedge avr_clk) avr_sreg_en_n = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge avr_clk);
            avr_si = v[n-1-i];
        end
        @(negedge avr_clk);
        avr_sreg_en_n = 1;
        if (cnt_fall) avr_counter_n = 0;
        @(negedge avr_clk);
    endtask

    task automatic pulse_cnt();
        @(negedge avr_clk) avr_counter_n = 0;
        @(negedge avr_clk) avr_counter_n = 1;
    endtask

    initial begin
        #2;
        chk("rst_addr", sram_addr, 24'h0);
        chk("rst_busy", {23'b0, busy}, 24'h0);
        chk("rst_done", {23'b0, load_done}, 24'h0);
        chk("rst_err", {23'b0, load_err}, 24'h0);
        @(negedge avr_clk) avr_reset_n = 1;
        @(negedge avr_clk);
        chk("post_rst_addr", sram_addr, 24'h0);

        load(32'h123456, 24, 0);
        chk("load_addr", sram_addr, 24'h123456);
        chk("load_done", {23'b0, load_done}, 24'h1);
        chk("load_busy", {23'b0, busy}, 24'h0);
        chk("load_no_err", {23'b0, load_err}, 24'h0);
        @(negedge avr_clk);
        chk("load_done_1cyc", {23'b0, load_done}, 24'h0);

        load(32'h2AA, 10, 0);
        chk("short_err", {23'b0, load_err}, 24'h1);
        chk("short_no_done", {23'b0, load_done}, 24'h0);
        chk("short_addr", sram_addr, 24'h123456);
        @(negedge avr_clk);
        chk("short_err_1cyc", {23'b0, load_err}, 24'h0);

        load(32'hA654321, 28, 0);
        chk("long_addr", sram_addr, 24'h654321);

        load(32'hFFFFFE, 24, 0);
        pulse_cnt();
        chk("inc1", sram_addr, 24'hFFFFFF);
        pulse_cnt();
        chk("inc_wrap", sram_addr, 24'h000000);

        @(negedge avr_clk) avr_sreg_en_n = 0;
        @(negedge avr_clk) avr_counter_n = 0;
        @(negedge avr_clk);
        chk("inc_in_shift_busy", {23'b0, busy}, 24'h1);
        avr_counter_n = 1;
        avr_sreg_en_n = 1;
        @(negedge avr_clk);
        @(negedge avr_clk);
        chk("inc_in_shift_ign", sram_addr, 24'h000000);

        load(32'h000010, 24, 1);
        chk("race_load_wins", sram_addr, 24'h000010);
        @(negedge avr_clk);
        chk("race_no_late_inc", sram_addr, 24'h000010);
        avr_counter_n = 1;

        avr_oe_n = 0; avr_we_n = 0; #1;
        chk("avr_rd_oe", {23'b0, sram_oe_n}, 24'h0);
        chk("avr_rd_we", {23'b0, sram_we_n}, 24'h1);
        avr_oe_n = 1; #1;
        chk("avr_wr_we", {23'b0, sram_we_n}, 24'h0);
        chk("avr_wr_oe", {23'b0, sram_oe_n}, 24'h1);
        avr_we_n = 1;

        avr_snes_mode = 1; snes_addr = 24'hABCDEF; snes_rd_n = 0; snes_wr_n = 0; #1;
        chk("snes_addr", sram_addr, 24'hABCDEF);
        chk("snes_oe", {23'b0, sram_oe_n}, 24'h0);
        chk("snes_we", {23'b0, sram_we_n}, 24'h1);
        snes_rd_n = 1; #1;
        chk("snes_wr_we", {23'b0, sram_we_n}, 24'h0);
        snes_wr_n = 1;
        avr_snes_mode = 0; #1;
        chk("avr_restored", sram_addr, 24'h000010);

        @(negedge avr_clk) avr_sreg_en_n = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge avr_clk);
            avr_si = i[0];
        end
        chk("midload_busy", {23'b0, busy}, 24'h1);
        #2 avr_reset_n = 0;
        #1;
        chk("midrst_busy", {23'b0, busy}, 24'h0);
        chk("midrst_addr", sram_addr, 24'h0);
        avr_sreg_en_n = 1;
        @(negedge avr_clk) avr_reset_n = 1;
        @(negedge avr_clk);
        chk("midrst_no_done", {23'b0, load_done}, 24'h0);
        chk("midrst_no_err", {23'b0, load_err}, 24'h0);
        @(negedge avr_clk);
        chk("midrst_no_err2", {23'b0, load_err}, 24'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
